// File: rtl/oc_bc_csr_responder_pkg.sv
// Shared definitions for the byte-channel CSR responder: command and status
// byte values, error-pulse bit positions and the responder FSM state type.
package oclib_bc_csr_pkg;

   localparam logic [7:0] CmdNop   = 8'h00;
   localparam logic [7:0] CmdRead  = 8'h01;
   localparam logic [7:0] CmdWrite = 8'h02;

   localparam logic [7:0] StatusOk       = 8'h00;
   localparam logic [7:0] StatusTimeout  = 8'h01;
   localparam logic [7:0] StatusCsrError = 8'h02;
   localparam logic [7:0] StatusBadCmd   = 8'h03;

   localparam int ErrBadCmd     = 0;
   localparam int ErrRxTimeout  = 1;
   localparam int ErrCsrTimeout = 2;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RX_ADDR   = 3'd1,
      ST_RX_DATA   = 3'd2,
      ST_CSR_REQ   = 3'd3,
      ST_TX_STATUS = 3'd4,
      ST_TX_DATA   = 3'd5
   } bc_state_e;

endpackage

// File: rtl/oc_bc_csr_responder_if.sv
// Byte-channel request/response streams plus the CSR bus, bundled so the
// responder and its neighbours connect through one port.
// slave  : the responder (consumes requests, drives the CSR bus)
// master : the controller / CSR target side
interface oc_bc_csr_responder_if;

   logic [7:0]  bcInData;
   logic        bcInValid;
   logic        bcInReady;
   logic [7:0]  bcOutData;
   logic        bcOutValid;
   logic        bcOutReady;
   logic [31:0] csrAddress;
   logic [31:0] csrWdata;
   logic        csrRead;
   logic        csrWrite;
   logic [31:0] csrRdata;
   logic        csrReady;
   logic        csrError;

   modport slave (
      input  bcInData, bcInValid, bcOutReady, csrRdata, csrReady, csrError,
      output bcInReady, bcOutData, bcOutValid, csrAddress, csrWdata, csrRead, csrWrite
   );

   modport master (
      output bcInData, bcInValid, bcOutReady, csrRdata, csrReady, csrError,
      input  bcInReady, bcOutData, bcOutValid, csrAddress, csrWdata, csrRead, csrWrite
   );

endinterface

// File: rtl/oc_bc_csr_responder.sv
// Register-access endpoint: turns byte-channel request frames into 32-bit
// CSR reads/writes and streams a status (+ read data) frame back.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// ST_IDLE      | waiting for a command byte; 0x00 is swallowed for resync
// ST_RX_ADDR   | shifting in 4 address bytes, MSB first
// ST_RX_DATA   | shifting in 4 write-data bytes (writes only)
// ST_CSR_REQ   | strobe held on the CSR bus until csrReady or timeout
// ST_TX_STATUS | presenting the status byte
// ST_TX_DATA   | presenting rdata bytes 31:24 down to 7:0 (OK reads only)
module oc_bc_csr_responder
   import oclib_bc_csr_pkg::*;
#(
   parameter int CsrTimeoutCycles = 1024,
   parameter int RxTimeoutCycles  = 100_000
) (
   input  logic                 clock,
   input  logic                 reset,
   oc_bc_csr_responder_if.slave bc,
   output logic [2:0]           error
);

   localparam int CsrCntW = $clog2(CsrTimeoutCycles + 1);
   localparam int RxCntW  = $clog2(RxTimeoutCycles + 1);
   localparam logic [CsrCntW-1:0] CsrLoad = CsrCntW'(CsrTimeoutCycles);
   localparam logic [RxCntW-1:0]  RxLoad  = RxCntW'(RxTimeoutCycles);

   bc_state_e          r_state,     w_nx_state;
   logic               r_in_ready,  w_nx_in_ready;
   logic               r_is_write,  w_nx_is_write;
   logic [1:0]         r_byte_cnt,  w_nx_byte_cnt;
   logic [31:0]        r_addr,      w_nx_addr;
   logic [31:0]        r_wdata,     w_nx_wdata;
   logic [31:0]        r_rdata,     w_nx_rdata;
   logic [7:0]         r_status,    w_nx_status;
   logic               r_csr_read,  w_nx_csr_read;
   logic               r_csr_write, w_nx_csr_write;
   logic [2:0]         r_error,     w_nx_error;
   logic [CsrCntW-1:0] r_csr_tmr,   w_nx_csr_tmr;
   logic [RxCntW-1:0]  r_rx_tmr,    w_nx_rx_tmr;

   logic       w_in_fire;
   logic       w_out_valid;
   logic       w_out_fire;
   logic [7:0] w_tx_byte;
   logic [7:0] w_out_data;

   // bcInReady is registered so it stays low through reset and rises one
   // clock after release; it always agrees with the receive states after that.
   assign w_in_fire   = bc.bcInValid & r_in_ready;
   assign w_out_valid = (r_state == ST_TX_STATUS) || (r_state == ST_TX_DATA);
   assign w_out_fire  = w_out_valid & bc.bcOutReady;
   // byte count 0 selects rdata[31:24], 3 selects rdata[7:0]
   assign w_tx_byte   = 8'(r_rdata >> {~r_byte_cnt, 3'b000});
   assign w_out_data  = (r_state == ST_TX_STATUS) ? r_status :
                        (r_state == ST_TX_DATA)   ? w_tx_byte : 8'h00;

   // Next-state and next-register values for the frame parser / responder.
   always_comb begin
      w_nx_state     = r_state;
      w_nx_is_write  = r_is_write;
      w_nx_byte_cnt  = r_byte_cnt;
      w_nx_addr      = r_addr;
      w_nx_wdata     = r_wdata;
      w_nx_rdata     = r_rdata;
      w_nx_status    = r_status;
      w_nx_csr_read  = r_csr_read;
      w_nx_csr_write = r_csr_write;
      w_nx_error     = 3'b000;
      w_nx_csr_tmr   = r_csr_tmr;
      w_nx_rx_tmr    = r_rx_tmr;

      case (r_state)
         ST_IDLE: begin
            if (w_in_fire) begin
               case (bc.bcInData)
                  CmdNop: begin
                  end
                  CmdRead, CmdWrite: begin
                     w_nx_is_write = (bc.bcInData == CmdWrite);
                     w_nx_byte_cnt = 2'd0;
                     w_nx_rx_tmr   = RxLoad;
                     w_nx_state    = ST_RX_ADDR;
                  end
                  default: begin
                     w_nx_error[ErrBadCmd] = 1'b1;
                     w_nx_status           = StatusBadCmd;
                     w_nx_state            = ST_TX_STATUS;
                  end
               endcase
            end
         end

         ST_RX_ADDR, ST_RX_DATA: begin
            if (w_in_fire) begin
               if (r_state == ST_RX_ADDR) w_nx_addr  = {r_addr[23:0], bc.bcInData};
               else                       w_nx_wdata = {r_wdata[23:0], bc.bcInData};
               w_nx_byte_cnt = r_byte_cnt + 2'd1;
               w_nx_rx_tmr   = RxLoad;
               if (r_byte_cnt == 2'd3) begin
                  if (r_state == ST_RX_ADDR && r_is_write) begin
                     w_nx_state = ST_RX_DATA;
                  end else begin
                     w_nx_csr_read  = ~r_is_write;
                     w_nx_csr_write = r_is_write;
                     w_nx_csr_tmr   = CsrLoad;
                     w_nx_state     = ST_CSR_REQ;
                  end
               end
            end else if (r_rx_tmr <= RxCntW'(1)) begin
               // partial frame abandoned: no response is owed
               w_nx_error[ErrRxTimeout] = 1'b1;
               w_nx_state               = ST_IDLE;
            end else begin
               w_nx_rx_tmr = r_rx_tmr - RxCntW'(1);
            end
         end

         ST_CSR_REQ: begin
            // csrReady takes priority over an expiring timer
            if (bc.csrReady) begin
               w_nx_csr_read  = 1'b0;
               w_nx_csr_write = 1'b0;
               w_nx_rdata     = bc.csrRdata;
               w_nx_status    = bc.csrError ? StatusCsrError : StatusOk;
               w_nx_state     = ST_TX_STATUS;
            end else if (r_csr_tmr <= CsrCntW'(1)) begin
               w_nx_csr_read             = 1'b0;
               w_nx_csr_write            = 1'b0;
               w_nx_error[ErrCsrTimeout] = 1'b1;
               w_nx_status               = StatusTimeout;
               w_nx_state                = ST_TX_STATUS;
            end else begin
               w_nx_csr_tmr = r_csr_tmr - CsrCntW'(1);
            end
         end

         ST_TX_STATUS: begin
            if (w_out_fire) begin
               if (!r_is_write && r_status == StatusOk) begin
                  w_nx_byte_cnt = 2'd0;
                  w_nx_state    = ST_TX_DATA;
               end else begin
                  w_nx_state = ST_IDLE;
               end
            end
         end

         ST_TX_DATA: begin
            if (w_out_fire) begin
               w_nx_byte_cnt = r_byte_cnt + 2'd1;
               if (r_byte_cnt == 2'd3) w_nx_state = ST_IDLE;
            end
         end

         default: begin
            w_nx_state = ST_IDLE;
         end
      endcase

      w_nx_in_ready = (w_nx_state == ST_IDLE) || (w_nx_state == ST_RX_ADDR) ||
                      (w_nx_state == ST_RX_DATA);
   end

   // State and datapath registers; reset aborts any frame or response at once.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b0;
         r_is_write  <= 1'b0;
         r_byte_cnt  <= 2'd0;
         r_addr      <= 32'h0;
         r_wdata     <= 32'h0;
         r_rdata     <= 32'h0;
         r_status    <= 8'h00;
         r_csr_read  <= 1'b0;
         r_csr_write <= 1'b0;
         r_error     <= 3'b000;
         r_csr_tmr   <= '0;
         r_rx_tmr    <= '0;
      end else begin
         r_state     <= w_nx_state;
         r_in_ready  <= w_nx_in_ready;
         r_is_write  <= w_nx_is_write;
         r_byte_cnt  <= w_nx_byte_cnt;
         r_addr      <= w_nx_addr;
         r_wdata     <= w_nx_wdata;
         r_rdata     <= w_nx_rdata;
         r_status    <= w_nx_status;
         r_csr_read  <= w_nx_csr_read;
         r_csr_write <= w_nx_csr_write;
         r_error     <= w_nx_error;
         r_csr_tmr   <= w_nx_csr_tmr;
         r_rx_tmr    <= w_nx_rx_tmr;
      end
   end

   assign bc.bcInReady  = r_in_ready;
   assign bc.bcOutValid = w_out_valid;
   assign bc.bcOutData  = w_out_data;
   assign bc.csrAddress = r_addr;
   assign bc.csrWdata   = r_wdata;
   assign bc.csrRead    = r_csr_read;
   assign bc.csrWrite   = r_csr_write;
   assign error         = r_error;

endmodule

// File: tb/tb_oc_bc_csr_responder.sv
// Bench for oc_bc_csr_responder: directed frames from the test plan followed
// by randomised read/write frames, all compared against a frame-level model.
module tb_oc_bc_csr_responder;
   import oclib_bc_csr_pkg::*;

   localparam int CsrTo = 16;
   localparam int RxTo  = 50;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] error;

   oc_bc_csr_responder_if bc_if ();

   oc_bc_csr_responder #(
      .CsrTimeoutCycles(CsrTo),
      .RxTimeoutCycles (RxTo)
   ) dut (
      .clock(clk),
      .reset(rst_n),
      .bc   (bc_if),
      .error(error)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- CSR target: answers after csr_delay strobe cycles (0 = never)
   int          csr_delay   = 1;
   logic        csr_err_cfg = 1'b0;
   logic [31:0] csr_rd_cfg  = 32'h0;
   bit          stray_ready = 1'b0;
   int          k           = 0;
   int          strobe_len  = 0;
   int          strobe_n    = 0;
   logic        cap_rd, cap_wr;
   logic [31:0] cap_addr, cap_wdata;

   initial begin
      bc_if.csrReady = 1'b0;
      bc_if.csrError = 1'b0;
      bc_if.csrRdata = 32'h0;
      forever begin
         @(negedge clk);
         if (bc_if.csrRead || bc_if.csrWrite) begin
            k++;
            if (k == 1) begin
               strobe_n++;
               cap_rd    = bc_if.csrRead;
               cap_wr    = bc_if.csrWrite;
               cap_addr  = bc_if.csrAddress;
               cap_wdata = bc_if.csrWdata;
            end
            strobe_len     = k;
            bc_if.csrReady = (k == csr_delay);
            bc_if.csrRdata = (k == csr_delay) ? csr_rd_cfg : 32'hBAD0_BAD0;
            bc_if.csrError = (k == csr_delay) ? csr_err_cfg : 1'b1;
         end else begin
            k              = 0;
            bc_if.csrReady = stray_ready;
            bc_if.csrError = stray_ready;
            bc_if.csrRdata = 32'hBAD0_BAD0;
         end
      end
   end

   // ---------------- response-side ready: 0 always, 1 toggle, 2 random, 3 manual
   int rdy_mode = 0;
   initial begin
      bc_if.bcOutReady = 1'b0;
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0:       bc_if.bcOutReady = 1'b1;
            1:       bc_if.bcOutReady = ~bc_if.bcOutReady;
            2:       bc_if.bcOutReady = 1'($urandom_range(0, 1));
            default: ;
         endcase
      end
   end

   // ---------------- monitor: collects response bytes, error pulses, hold rule
   logic [7:0] out_q[$];
   int         err_cnt[3];
   logic       prev_hold = 1'b0;
   logic [7:0] prev_data = 8'h00;

   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (!rst_n) begin
            prev_hold = 1'b0;
         end else begin
            if (prev_hold) begin
               check("out_hold_valid", 32'(bc_if.bcOutValid), 1);
               check("out_hold_data", 32'(bc_if.bcOutData), 32'(prev_data));
            end
            if (bc_if.bcOutValid && bc_if.bcOutReady) out_q.push_back(bc_if.bcOutData);
            prev_hold = bc_if.bcOutValid && !bc_if.bcOutReady;
            prev_data = bc_if.bcOutData;
            for (int i = 0; i < 3; i++) if (error[i]) err_cnt[i]++;
            if (bc_if.csrRead || bc_if.csrWrite) check("inready_during_csr", 32'(bc_if.bcInReady), 0);
         end
      end
   end

   // ---------------- frame-level reference model
   logic [7:0] tx_q[$];
   logic [7:0] exp_q[$];
   int         lat;

   function automatic logic [7:0] exp_status(input int delay, input logic err);
      if (delay < 1 || delay > CsrTo) return StatusTimeout;
      return err ? StatusCsrError : StatusOk;
   endfunction

   task automatic build_frame(input logic is_wr, input logic [31:0] addr, input logic [31:0] wd,
                              input int delay, input logic err, input logic [31:0] rd);
      logic [7:0] st;
      st = exp_status(delay, err);
      tx_q.push_back(is_wr ? CmdWrite : CmdRead);
      for (int i = 3; i >= 0; i--) tx_q.push_back(addr[8*i +: 8]);
      if (is_wr) for (int i = 3; i >= 0; i--) tx_q.push_back(wd[8*i +: 8]);
      exp_q.push_back(st);
      if (!is_wr && st == StatusOk) for (int i = 3; i >= 0; i--) exp_q.push_back(rd[8*i +: 8]);
   endtask

   task automatic clear_obs();
      out_q.delete();
      foreach (err_cnt[i]) err_cnt[i] = 0;
      strobe_n = 0;
   endtask

   // called at a negedge; returns at the negedge after the byte transferred
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      bc_if.bcInData  = b;
      bc_if.bcInValid = 1'b1;
      while (bc_if.bcInReady !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", 32'(n < 300), 1);
      @(negedge clk);
      bc_if.bcInValid = 1'b0;
   endtask

   task automatic run_frames(input string tag);
      int n;
      clear_obs();
      foreach (tx_q[i]) send_byte(tx_q[i]);
      n = 0;
      while (bc_if.bcOutValid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      lat = n;
      n = 0;
      while ((out_q.size() < exp_q.size() || bc_if.bcOutValid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done"}, 32'(n < 500), 1);
      repeat (4) @(negedge clk);
      check({tag, "_len"}, out_q.size(), exp_q.size());
      foreach (exp_q[i])
         check($sformatf("%s_b%0d", tag, i),
               (i < out_q.size()) ? {24'h0, out_q[i]} : 32'hFFFF_FFFF, {24'h0, exp_q[i]});
      tx_q.delete();
      exp_q.delete();
   endtask

   task automatic check_txn(input string tag, input logic is_wr, input logic [31:0] addr,
                            input logic [31:0] wd, input int delay);
      logic to;
      to = (exp_status(delay, 1'b0) == StatusTimeout);
      check({tag, "_nstrobe"}, strobe_n, 1);
      check({tag, "_rd"}, 32'(cap_rd), 32'(!is_wr));
      check({tag, "_wr"}, 32'(cap_wr), 32'(is_wr));
      check({tag, "_addr"}, cap_addr, addr);
      if (is_wr) check({tag, "_wdata"}, cap_wdata, wd);
      check({tag, "_slen"}, strobe_len, to ? CsrTo : delay);
      check({tag, "_err2"}, err_cnt[ErrCsrTimeout], 32'(to));
      check({tag, "_err0"}, err_cnt[ErrBadCmd], 0);
      check({tag, "_err1"}, err_cnt[ErrRxTimeout], 0);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed + random sequence
   initial begin
      logic        r_wr, r_e;
      logic [31:0] r_a, r_d, r_rd;
      int          r_dly, n;

      bc_if.bcInValid = 1'b0;
      bc_if.bcInData  = 8'h00;
      foreach (err_cnt[i]) err_cnt[i] = 0;
      repeat (3) @(negedge clk);

      check("rst_inready", 32'(bc_if.bcInReady), 0);
      check("rst_outvalid", 32'(bc_if.bcOutValid), 0);
      check("rst_outdata", 32'(bc_if.bcOutData), 0);
      check("rst_csrread", 32'(bc_if.csrRead), 0);
      check("rst_csrwrite", 32'(bc_if.csrWrite), 0);
      check("rst_addr", bc_if.csrAddress, 0);
      check("rst_wdata", bc_if.csrWdata, 0);
      check("rst_error", 32'(error), 0);
      rst_n = 1'b1;
      #1 check("rel_inready_low", 32'(bc_if.bcInReady), 0);
      @(negedge clk);
      check("rel_inready_high", 32'(bc_if.bcInReady), 1);

      // write 0x10 <- DEADBEEF, ready after 3 strobe cycles
      csr_delay = 3; csr_err_cfg = 1'b0; rdy_mode = 0;
      build_frame(1'b1, 32'h10, 32'hDEAD_BEEF, 3, 1'b0, 32'h0);
      run_frames("wr");
      check_txn("wr", 1'b1, 32'h10, 32'hDEAD_BEEF, 3);

      // read 0x20 -> 12345678 with toggling bcOutReady
      csr_delay = 2; csr_rd_cfg = 32'h1234_5678; rdy_mode = 1;
      build_frame(1'b0, 32'h20, 32'h0, 2, 1'b0, 32'h1234_5678);
      run_frames("rd");
      check_txn("rd", 1'b0, 32'h20, 32'h0, 2);

      // minimum latency: ready in first strobe cycle, valid two cycles after last byte
      csr_delay = 1; csr_rd_cfg = 32'hA5A5_0F0F; rdy_mode = 0;
      build_frame(1'b0, 32'hCAFE_0004, 32'h0, 1, 1'b0, 32'hA5A5_0F0F);
      run_frames("minlat");
      check("minlat_cycles", lat, 1);

      // resync bytes then a bad command
      tx_q = '{8'h00, 8'h00, 8'h7F};
      exp_q = '{StatusBadCmd};
      run_frames("badcmd");
      check("badcmd_err0", err_cnt[ErrBadCmd], 1);
      check("badcmd_nstrobe", strobe_n, 0);
      csr_delay = 2; csr_rd_cfg = 32'h0BAD_F00D;
      build_frame(1'b0, 32'h44, 32'h0, 2, 1'b0, 32'h0BAD_F00D);
      run_frames("after_bad");
      check_txn("after_bad", 1'b0, 32'h44, 32'h0, 2);

      // CSR timeout, then ready exactly on the last allowed cycle, then csrError
      csr_delay = 0;
      build_frame(1'b0, 32'h80, 32'h0, 0, 1'b0, 32'h0);
      run_frames("csrto");
      check_txn("csrto", 1'b0, 32'h80, 32'h0, 0);
      csr_delay = CsrTo; csr_rd_cfg = 32'h8765_4321;
      build_frame(1'b0, 32'h84, 32'h0, CsrTo, 1'b0, 32'h8765_4321);
      run_frames("csr_edge");
      check_txn("csr_edge", 1'b0, 32'h84, 32'h0, CsrTo);
      csr_err_cfg = 1'b1; csr_delay = 5;
      build_frame(1'b0, 32'h88, 32'h0, 5, 1'b1, 32'h8765_4321);
      run_frames("csrerr");
      check_txn("csrerr", 1'b0, 32'h88, 32'h0, 5);
      csr_err_cfg = 1'b0;

      // RX timeout on a partial frame
      clear_obs();
      send_byte(CmdRead); send_byte(8'h00); send_byte(8'h00);
      repeat (45) @(negedge clk);
      check("rxto_early", err_cnt[ErrRxTimeout], 0);
      repeat (25) @(negedge clk);
      check("rxto_pulse", err_cnt[ErrRxTimeout], 1);
      check("rxto_noresp", out_q.size(), 0);
      check("rxto_nostrobe", strobe_n, 0);
      csr_delay = 1; csr_rd_cfg = 32'h5566_7788;
      build_frame(1'b0, 32'h90, 32'h0, 1, 1'b0, 32'h5566_7788);
      run_frames("after_rxto");
      check_txn("after_rxto", 1'b0, 32'h90, 32'h0, 1);

      // back-to-back frames: second frame back-pressured, not dropped
      csr_delay = 4; csr_rd_cfg = 32'h0102_0304;
      build_frame(1'b1, 32'hA0, 32'h1111_2222, 4, 1'b0, 32'h0);
      build_frame(1'b0, 32'hA4, 32'h0, 4, 1'b0, 32'h0102_0304);
      run_frames("b2b");
      check("b2b_nstrobe", strobe_n, 2);

      // csrReady outside CSR_REQ is ignored
      clear_obs();
      stray_ready = 1'b1;
      repeat (10) @(negedge clk);
      stray_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("stray_noresp", out_q.size(), 0);
      check("stray_noerr", 32'(err_cnt[0] + err_cnt[1] + err_cnt[2]), 0);

      // randomised frames
      for (int it = 0; it < 24; it++) begin
         r_wr  = 1'($urandom_range(0, 1));
         r_a   = $urandom;
         r_d   = $urandom;
         r_rd  = $urandom;
         r_dly = $urandom_range(0, 19);
         r_e   = 1'($urandom_range(0, 1));
         csr_delay = r_dly; csr_err_cfg = r_e; csr_rd_cfg = r_rd;
         rdy_mode  = $urandom_range(0, 2);
         build_frame(r_wr, r_a, r_d, r_dly, r_e, r_rd);
         run_frames($sformatf("rnd%0d", it));
         check_txn($sformatf("rnd%0d", it), r_wr, r_a, r_d, r_dly);
      end
      rdy_mode = 0; csr_err_cfg = 1'b0;

      // reset while the CSR strobe is held
      csr_delay = 0;
      build_frame(1'b0, 32'hB0, 32'h0, 0, 1'b0, 32'h0);
      foreach (tx_q[i]) send_byte(tx_q[i]);
      tx_q.delete(); exp_q.delete();
      check("rstcsr_strobe_on", 32'(bc_if.csrRead), 1);
      #1 rst_n = 1'b0;
      #1 check("rstcsr_strobe_off", 32'(bc_if.csrRead), 0);
      check("rstcsr_addr", bc_if.csrAddress, 0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      check("rstcsr_inready", 32'(bc_if.bcInReady), 1);

      // reset after the status byte of a read has been accepted
      csr_delay = 1; csr_rd_cfg = 32'hFACE_B00C; rdy_mode = 3;
      bc_if.bcOutReady = 1'b0;
      build_frame(1'b0, 32'hC0, 32'h0, 1, 1'b0, 32'hFACE_B00C);
      foreach (tx_q[i]) send_byte(tx_q[i]);
      tx_q.delete(); exp_q.delete();
      n = 0;
      while (bc_if.bcOutValid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("rstrsp_status", 32'(bc_if.bcOutData), 32'(StatusOk));
      bc_if.bcOutReady = 1'b1;
      @(negedge clk);
      bc_if.bcOutReady = 1'b0;
      check("rstrsp_data_valid", 32'(bc_if.bcOutValid), 1);
      check("rstrsp_data0", 32'(bc_if.bcOutData), 32'hFA);
      #1 rst_n = 1'b0;
      #1 check("rstrsp_outvalid", 32'(bc_if.bcOutValid), 0);
      check("rstrsp_outdata", 32'(bc_if.bcOutData), 0);
      check("rstrsp_csrread", 32'(bc_if.csrRead), 0);
      @(negedge clk) rst_n = 1'b1;
      #1 check("rstrsp_inready_low", 32'(bc_if.bcInReady), 0);
      @(negedge clk);
      check("rstrsp_inready_high", 32'(bc_if.bcInReady), 1);
      rdy_mode = 0; csr_delay = 2; csr_rd_cfg = 32'h7777_0001;
      build_frame(1'b0, 32'hC4, 32'h0, 2, 1'b0, 32'h7777_0001);
      run_frames("after_rst");
      check_txn("after_rst", 1'b0, 32'hC4, 32'h0, 2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
